// File: rtl/reg_dump_reader.sv
// reg_dump_reader: sweeps rID across the register file after a run and streams each rdata word out.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum word (out_idx all-ones) to every dump.
`default_nettype none

module reg_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int ID_W     = 4,
  parameter int READ_LAT = 1
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            working,
  input  logic            start,
  input  logic [31:0]     rdata,
  output logic [ID_W-1:0] rID,
  output logic [31:0]     out_data,
  output logic [ID_W-1:0] out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_CSUM    = 3'd4
  } state_t;

  localparam logic [ID_W-1:0] IDLE_ID  = '1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REGS - 1);
  localparam logic [1:0]      LAT      = 2'(READ_LAT);

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic [ID_W-1:0] r_idx;
  logic [ID_W-1:0] r_rid;
  logic [31:0]     r_data;
  logic [ID_W-1:0] r_oidx;
  logic            r_valid;
  logic            r_last;
  logic            r_busy;
  logic            r_done;
  logic            r_work_prev;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0]     r_xor;
`endif

  logic w_fall;
  logic w_rise;
  logic w_trig;

  assign w_fall = r_work_prev & ~working;
  assign w_rise = ~r_work_prev & working;
  // A start coinciding with the done pulse must not launch a new dump.
  assign w_trig = (w_fall | start) & ~r_done;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rid       <= IDLE_ID;
      r_data      <= '0;
      r_oidx      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_work_prev <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_work_prev <= working;
      r_done      <= 1'b0;
      if (r_busy && w_rise) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_rid   <= IDLE_ID;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_trig) begin
              r_idx   <= '0;
              r_rid   <= '0;
              r_busy  <= 1'b1;
              r_cnt   <= LAT;
              r_state <= (READ_LAT == 0) ? S_CAPTURE : S_WAIT;
`ifdef REG_DUMP_CHECKSUM_EN
              r_xor   <= '0;
`endif
            end
          end
          S_WAIT: begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt <= 2'd1) r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_data  <= rdata;
            r_oidx  <= r_idx;
            r_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            r_last  <= 1'b0;
            r_xor   <= r_xor ^ rdata;
`else
            r_last  <= (r_idx == LAST_IDX);
`endif
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            if (out_ready) begin
              r_valid <= 1'b0;
              if (r_last) begin
                r_rid   <= IDLE_ID;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
              end else if (r_idx == LAST_IDX) begin
                r_rid   <= IDLE_ID;
                r_state <= S_CSUM;
`endif
              end else begin
                r_idx   <= r_idx + ID_W'(1);
                r_rid   <= r_idx + ID_W'(1);
                r_cnt   <= LAT;
                r_state <= (READ_LAT == 0) ? S_CAPTURE : S_WAIT;
              end
            end
          end
          S_CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
            r_data  <= r_xor;
            r_oidx  <= IDLE_ID;
            r_last  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
`else
            r_state <= S_IDLE;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rID       = r_rid;
  assign out_data  = r_data;
  assign out_idx   = r_oidx;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Post-run readback engine for the processor's register-file debug port.
- The program loader writes instruction memory over addr/wr/wdata while working=0; this block is the read side of the same debug path.
- When the processor stops (working falls) or on an explicit start pulse, it sweeps rID across the architectural registers and captures rdata. Each word is emitted on a valid/ready stream toward the host/trace logic.

Parameters:
- NUM_REGS, 8, number of registers swept (r0..r(NUM_REGS-1)); legal 1..15.
- ID_W, 4, width of rID.
- READ_LAT, 1, cycles from an rID change to rdata valid; legal 0..3.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- working  in  1  processor run enable; a 1->0 transition triggers a dump.
- start  in  1  single-cycle manual dump request.
- rdata  in  32  register read data from the processor.
- rID  out  ID_W  register select toward the processor.
- out_data  out  32  dumped register value.
- out_idx  out  ID_W  register index of out_data.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_last  out  1  marks the final word of a dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset (async, rst_n=0), all outputs forced immediately:
  - rID = all-ones (idle select, 4'hF);
  - out_data = 0, out_idx = 0;
  - out_valid = 0, out_last = 0;
  - busy = 0, done = 0;
  - state = IDLE;
  - working-edge register = 0.
- Trigger:
  - working is registered each cycle; fall = prev & ~working.
  - Trigger = fall | start, accepted only in IDLE; ignored while busy.
- FSM:
  - IDLE: on trigger, set idx=0, rID<=0, busy<=1, then go to WAIT with a latency counter of READ_LAT. If READ_LAT=0, go directly to CAPTURE.
  - WAIT: decrement the counter; go to CAPTURE when it reaches 0.
  - CAPTURE: set out_data<=rdata, out_idx<=idx, out_valid<=1, and out_last<=(idx==NUM_REGS-1, or checksum word pending, see optional feature). Go to HOLD.
  - HOLD: keep out_* stable while out_valid & ~out_ready. On handshake, out_valid<=0, then:
    - if not last: idx+1, rID<=idx+1, go to WAIT;
    - if last: rID<=all-ones, busy<=0, done<=1 for one cycle, go to IDLE.
- Throughput: one word per READ_LAT+2 cycles with out_ready held high.
- Backpressure: out_data, out_idx and out_last must not change while out_valid=1 and out_ready=0. rID is held constant during HOLD.
- Abort: if working rises while busy, return to IDLE next cycle.
  - out_valid<=0, rID<=all-ones, busy<=0, no done pulse.
  - A word in HOLD is dropped.
- Simultaneous fall and start in IDLE: a single dump is started.
- A start arriving in the same cycle as done is ignored.
- idx arithmetic: ID_W bits. NUM_REGS<=15 guarantees no wrap into the idle code.
- Reset mid-dump: immediate return to reset values; no partial words are emitted afterwards.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every captured word is maintained, cleared on trigger.
  - After register NUM_REGS-1 is accepted, one extra word is emitted: out_data=XOR, out_idx=all-ones, out_last=1.
  - Register NUM_REGS-1 is then not marked last.
  - done pulses after the checksum word handshake.
- Undefined:
  - No checksum word; out_last is on register NUM_REGS-1.
  - No XOR register is synthesised.

Test Plan:
- Bench model with rdata = 0x80+rID (READ_LAT=1), working 1->0, out_ready=1 -> 8 words (idx 0..7, data 0x80..0x87), out_last on idx 7, one-cycle done, rID back to 4'hF, busy low.
- Same stimulus, out_ready toggled 0/1 every 3 cycles -> identical sequence, with out_data stable through every stall cycle.
- start pulse while busy mid-dump (after idx 3) -> ignored; still exactly 8 words and a single done.
- working re-asserted after idx 2 is accepted -> out_valid low next cycle, busy=0, no done, rID=4'hF. A subsequent start produces a full dump.
- rst_n pulled low while in HOLD at idx 5 -> outputs reset immediately without a clock edge; no further words after release.
- REG_DUMP_CHECKSUM_EN defined, data 0x80..0x87 -> 9th word out_idx=4'hF, out_data=0x00000000 (XOR of 0x80..0x87), out_last only on that word.
